// File: rtl/agc_prefix_decode_stage.sv
`default_nettype none
// ============================================================================
// Module   : agc_prefix_decode_stage
// Purpose  : AGC front-end decode stage. Tracks the EXTEND / INDEX prefix
//            state across instructions and adds the held index to the next
//            instruction word. For every instruction that is not a prefix,
//            it registers one decode record (address class, quarter, halt
//            flag) behind a valid/ready handshake.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clock        in   1       system clock
//   rst_l        in   1       asynchronous active-low reset
//   flush        in   1       synchronous pipeline flush (highest priority)
//   in_valid     in   1       fetch presents an instruction
//   in_ready     out  1       instruction accepted this cycle
//   in_instr     in   WORD_W  raw instruction word
//   in_pc        in   ADDR_W  address of in_instr
//   index_data   in   WORD_W  indexed memory word, sampled on INDEX accept
//   out_valid    out  1       decode record valid
//   out_ready    in   1       downstream consumes the record
//   out_instr    out  WORD_W  effective instruction (index applied)
//   out_pc       out  ADDR_W  pc of the emitted instruction
//   out_extended out  1       instruction executes as an extracode
//   out_class    out  4       {out_extended, opcode}
//   out_quarter  out  2       effective address quarter
//   out_region   out  2       0 REG, 1 ERASABLE, 2 FIXED
//   out_halt     out  1       halt / illegal extracode
// ============================================================================
module agc_prefix_decode_stage #(
  parameter int WORD_W       = 15,
  parameter int ADDR_W       = 12,
  parameter int NUM_REGS     = 13,
  parameter int ERASABLE_TOP = 'o2000
) (
  input  logic              clock,
  input  logic              rst_l,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_instr,
  input  logic [ADDR_W-1:0] in_pc,
  input  logic [WORD_W-1:0] index_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_instr,
  output logic [ADDR_W-1:0] out_pc,
  output logic              out_extended,
  output logic [3:0]        out_class,
  output logic [1:0]        out_quarter,
  output logic [1:0]        out_region,
  output logic              out_halt
);

  // Prefix FSM states
  localparam logic [1:0] ST_NORM    = 2'd0;
  localparam logic [1:0] ST_EXT     = 2'd1;
  localparam logic [1:0] ST_IDX     = 2'd2;
  localparam logic [1:0] ST_EXT_IDX = 2'd3;

  localparam logic [1:0] RGN_REG      = 2'd0;
  localparam logic [1:0] RGN_ERASABLE = 2'd1;
  localparam logic [1:0] RGN_FIXED    = 2'd2;

  localparam logic [WORD_W-1:0] EXTEND_WORD = WORD_W'(6);
  localparam logic [2:0]        OP_INDEX    = 3'd5;
  localparam logic [2:0]        OP_HALT     = 3'd3;
  localparam logic [2:0]        OP_ZERO     = 3'd0;

  // State
  logic [1:0]        state_q, state_d;
  logic [WORD_W-1:0] idx_q, idx_d;
  logic              halted_q, halted_d;

  logic              out_valid_q, out_valid_d;
  logic [WORD_W-1:0] out_instr_q;
  logic [ADDR_W-1:0] out_pc_q;
  logic              out_ext_q;
  logic [3:0]        out_class_q;
  logic [1:0]        out_quarter_q;
  logic [1:0]        out_region_q;
  logic              out_halt_q;

  // Decode of the current input
  logic              extended;
  logic              indexed;
  logic [WORD_W-1:0] eff;
  logic [2:0]        opcode;
  logic [1:0]        quarter;
  logic [ADDR_W-1:0] addr;
  logic              is_extend;
  logic              is_index;
  logic              accept;
  logic              emit;
  logic              halt;
  logic [1:0]        region;

  assign extended = (state_q == ST_EXT) || (state_q == ST_EXT_IDX);
  assign indexed  = (state_q == ST_IDX) || (state_q == ST_EXT_IDX);

  // Index add wraps modulo 2^WORD_W.
  assign eff     = indexed ? (in_instr + idx_q) : in_instr;
  assign opcode  = eff[WORD_W-1 -: 3];
  assign quarter = eff[ADDR_W-1 -: 2];
  assign addr    = eff[ADDR_W-1:0];

  // An EXTEND word seen while already extended is not a prefix; it falls
  // through as an ordinary extracode. Extended INDEX ignores the quarter.
  assign is_extend = !extended && (eff == EXTEND_WORD);
  assign is_index  = (opcode == OP_INDEX) && (extended || (quarter == 2'd0));

  assign in_ready = !halted_q && !flush && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign emit     = accept && !is_extend && !is_index;

  assign halt = extended &&
                ((opcode == OP_HALT) ||
                 ((opcode == OP_ZERO) && (eff[ADDR_W-1 -: 3] == 3'b111)));

  always_comb begin
    region = RGN_FIXED;
    if (addr < ADDR_W'(NUM_REGS)) begin
      region = RGN_REG;
    end else if (addr < ADDR_W'(ERASABLE_TOP)) begin
      region = RGN_ERASABLE;
    end
  end

  // Next-state logic
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    halted_d    = halted_q;
    out_valid_d = out_valid_q;

    if (flush) begin
      state_d     = ST_NORM;
      idx_d       = '0;
      halted_d    = 1'b0;
      out_valid_d = 1'b0;
    end else begin
      if (accept) begin
        if (is_extend) begin
          // EXTEND after INDEX discards the pending index.
          state_d = ST_EXT;
          idx_d   = '0;
        end else if (is_index) begin
          // A chained INDEX replaces the held value rather than summing.
          state_d = extended ? ST_EXT_IDX : ST_IDX;
          idx_d   = index_data;
        end else begin
          state_d = ST_NORM;
          idx_d   = '0;
          if (halt) begin
            halted_d = 1'b1;
          end
        end
      end

      if (emit) begin
        out_valid_d = 1'b1;
      end else if (out_ready) begin
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clock or negedge rst_l) begin
    if (!rst_l) begin
      state_q     <= ST_NORM;
      idx_q       <= '0;
      halted_q    <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      halted_q    <= halted_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Record payload only changes on an emit, so it holds under backpressure.
  always_ff @(posedge clock or negedge rst_l) begin
    if (!rst_l) begin
      out_instr_q   <= '0;
      out_pc_q      <= '0;
      out_ext_q     <= 1'b0;
      out_class_q   <= '0;
      out_quarter_q <= '0;
      out_region_q  <= '0;
      out_halt_q    <= 1'b0;
    end else if (emit) begin
      out_instr_q   <= eff;
      out_pc_q      <= in_pc;
      out_ext_q     <= extended;
      out_class_q   <= {extended, opcode};
      out_quarter_q <= quarter;
      out_region_q  <= region;
      out_halt_q    <= halt;
    end
  end

  assign out_valid    = out_valid_q;
  assign out_instr    = out_instr_q;
  assign out_pc       = out_pc_q;
  assign out_extended = out_ext_q;
  assign out_class    = out_class_q;
  assign out_quarter  = out_quarter_q;
  assign out_region   = out_region_q;
  assign out_halt     = out_halt_q;

endmodule
`default_nettype wire

// File: tb/tb_agc_prefix_decode_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_agc_prefix_decode_stage
// Purpose  : Self-checking bench for agc_prefix_decode_stage. A reference
//            model predicts each decode record at acceptance and queues it;
//            a monitor pops and compares on every output handshake.
// Revision : 1.0 - initial release
// ============================================================================
module tb_agc_prefix_decode_stage;

  logic        clock = 1'b0;
  logic        rst_l = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [14:0] in_instr = '0;
  logic [11:0] in_pc = '0;
  logic [14:0] index_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [14:0] out_instr;
  logic [11:0] out_pc;
  logic        out_extended;
  logic [3:0]  out_class;
  logic [1:0]  out_quarter;
  logic [1:0]  out_region;
  logic        out_halt;

  agc_prefix_decode_stage dut (
    .clock        (clock),
    .rst_l        (rst_l),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_instr     (in_instr),
    .in_pc        (in_pc),
    .index_data   (index_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_instr    (out_instr),
    .out_pc       (out_pc),
    .out_extended (out_extended),
    .out_class    (out_class),
    .out_quarter  (out_quarter),
    .out_region   (out_region),
    .out_halt     (out_halt)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [14:0] instr;
    logic [11:0] pc;
    logic        ext;
    logic [3:0]  cls;
    logic [1:0]  qtr;
    logic [1:0]  rgn;
    logic        halt;
  } rec_t;

  rec_t sb[$];
  rec_t mon_e;

  int n_total = 0;
  int n_bad   = 0;
  bit rand_bp = 1'b0;

  // Reference prefix model
  bit          m_ext    = 1'b0;
  bit          m_idx_on = 1'b0;
  logic [14:0] m_idx    = '0;
  bit          m_halted = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 'h%0h expected 'h%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_ext = 1'b0; m_idx_on = 1'b0; m_idx = '0; m_halted = 1'b0;
  endtask

  task automatic model_accept(input logic [14:0] ins, input logic [11:0] pc,
                              input logic [14:0] dat);
    logic [14:0] e;
    logic [2:0]  op;
    logic [11:0] a;
    rec_t        r;
    e  = m_idx_on ? 15'(ins + m_idx) : ins;
    op = e[14:12];
    a  = e[11:0];
    if (!m_ext && e == 15'o00006) begin
      m_ext = 1'b1; m_idx_on = 1'b0;
    end else if (op == 3'd5 && (m_ext || e[11:10] == 2'b00)) begin
      m_idx_on = 1'b1; m_idx = dat;
    end else begin
      r.instr = e;
      r.pc    = pc;
      r.ext   = m_ext;
      r.cls   = {m_ext, op};
      r.qtr   = e[11:10];
      r.rgn   = (a < 12'd13) ? 2'd0 : (a < 12'o2000) ? 2'd1 : 2'd2;
      r.halt  = m_ext && (op == 3'd3 || (op == 3'd0 && e[11:9] == 3'b111));
      sb.push_back(r);
      if (r.halt) m_halted = 1'b1;
      m_ext = 1'b0; m_idx_on = 1'b0;
    end
  endtask

  // Present one instruction and hold it until accepted (bounded).
  task automatic send(input logic [14:0] ins, input logic [11:0] pc, input logic [14:0] dat);
    in_valid = 1'b1; in_instr = ins; in_pc = pc; index_data = dat;
    for (int t = 0; ; t++) begin
      @(negedge clock);
      if (in_ready) begin
        model_accept(ins, pc, dat);
        break;
      end
      if (t >= 60) begin
        chk("accept_timeout", 0, 1);
        break;
      end
      @(posedge clock); #1;
      if (rand_bp) out_ready = 1'($urandom_range(0, 1));
    end
    @(posedge clock); #1;
    in_valid = 1'b0;
    if (rand_bp) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int t = 0; t < 40 && sb.size() != 0; t++) begin
      @(posedge clock); #1;
    end
    chk("drain_empty", sb.size(), 0);
  endtask

  task automatic do_flush();
    in_valid = 1'b0;
    flush = 1'b1;
    @(negedge clock);
    chk("flush_in_ready_low", in_ready, 0);
    @(posedge clock); #1;
    flush = 1'b0;
    model_clear();
    @(negedge clock);
    chk("post_flush_in_ready", in_ready, 1);
    chk("post_flush_out_valid", out_valid, 0);
    @(posedge clock); #1;
  endtask

  // Output monitor: one scoreboard pop per handshake.
  always @(negedge clock) begin
    if (rst_l && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("spurious_record", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        chk("out_instr",    out_instr,    mon_e.instr);
        chk("out_pc",       out_pc,       mon_e.pc);
        chk("out_extended", out_extended, mon_e.ext);
        chk("out_class",    out_class,    mon_e.cls);
        chk("out_quarter",  out_quarter,  mon_e.qtr);
        chk("out_region",   out_region,   mon_e.rgn);
        chk("out_halt",     out_halt,     mon_e.halt);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_instr", out_instr, 0);
    chk("rst_out_class", out_class, 0);
    chk("rst_out_halt",  out_halt,  0);
    @(posedge clock); @(posedge clock); #1;
    rst_l = 1'b1;
    @(negedge clock);
    chk("rst_in_ready", in_ready, 1);
    @(posedge clock); #1;

    // Extracode
    send(15'o00006, 12'o0000, 15'o0);
    send(15'o10012, 12'o2100, 15'o0);
    drain();

    // Index add then index consumed
    send(15'o50100, 12'o0010, 15'o00003);
    send(15'o30020, 12'o0011, 15'o0);
    send(15'o30020, 12'o0012, 15'o0);
    drain();

    // Extended index
    send(15'o00006, 12'o0020, 15'o0);
    send(15'o50200, 12'o0021, 15'o00005);
    send(15'o70030, 12'o0022, 15'o0);
    drain();

    // Backpressure: record held, in_ready low, outputs stable
    out_ready = 1'b0;
    send(15'o10012, 12'o0100, 15'o0);
    in_valid = 1'b1; in_instr = 15'o20040; in_pc = 12'o0101;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      chk("bp_in_ready",  in_ready,  0);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_out_instr", out_instr, 15'o10012);
      chk("bp_out_pc",    out_pc,    12'o0100);
      @(posedge clock); #1;
    end
    out_ready = 1'b1;
    send(15'o20040, 12'o0101, 15'o0);
    @(negedge clock);
    chk("b2b_out_valid", out_valid, 1);
    chk("b2b_out_instr", out_instr, 15'o20040);
    @(posedge clock); #1;
    drain();

    // Sticky halt
    send(15'o00006, 12'o0200, 15'o0);
    send(15'o30000, 12'o0201, 15'o0);
    drain();
    in_valid = 1'b1; in_instr = 15'o10000; in_pc = 12'o0202;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      chk("halt_in_ready", in_ready, 0);
      @(posedge clock); #1;
    end
    do_flush();
    send(15'o10012, 12'o0203, 15'o0);
    drain();

    // Flush mid-prefix
    send(15'o00006, 12'o0300, 15'o0);
    do_flush();
    send(15'o10012, 12'o0301, 15'o0);
    drain();

    // Async reset while a record is pending
    out_ready = 1'b0;
    send(15'o10012, 12'o0077, 15'o0);
    #2;
    rst_l = 1'b0;
    #1;
    chk("async_rst_out_valid", out_valid, 0);
    sb.delete();
    model_clear();
    @(posedge clock); #1;
    rst_l = 1'b1;
    out_ready = 1'b1;
    @(negedge clock);
    chk("post_rst_out_valid", out_valid, 0);
    @(posedge clock); #1;

    // Random mix with random backpressure
    rand_bp = 1'b1;
    for (int i = 0; i < 60; i++) begin
      logic [14:0] ins;
      int sel;
      sel = $urandom_range(0, 3);
      if (sel == 0)      ins = 15'o00006;
      else if (sel == 1) ins = {3'd5, 2'b00, 10'($urandom)};
      else               ins = 15'($urandom);
      send(ins, 12'($urandom), 15'($urandom));
      if (m_halted) begin
        rand_bp = 1'b0;
        drain();
        do_flush();
        rand_bp = 1'b1;
      end
    end
    rand_bp = 1'b0;
    drain();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
